// File: rtl/dftprobe_pkg.sv
// Shared types and helpers for the multi-channel DFT TDI probe.
// Mode encodings, the config-width rule and an elaboration-time clog2.
package dftprobe_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_LIVE   = 2'b01,
        MODE_HOLD   = 2'b10,
        MODE_STICKY = 2'b11
    } mode_e;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Config word is {mode[1:0], sel[selw-1:0]}.
    function automatic int cfg_width(input int selw);
        return selw + 2;
    endfunction

endpackage

// File: rtl/dftprobe_sync.sv
// Generic W-bit, STAGES-deep flop synchroniser with async active-low reset.
module dftprobe_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [STAGES-1:0][W-1:0] r_stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/dftprobe_chain.sv
// Multi-channel DFT TDI probe: synchronised enable and probes, serially loaded
// config with daisy-chain output, and OFF/LIVE/HOLD/STICKY output modes.
module dftprobe_chain
    import dftprobe_pkg::*;
#(
    parameter int NCH         = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           CELV,
    input  logic           CELG,
    input  logic           CELSUB,
    input  logic           ten_encore,
    input  logic [NCH-1:0] i,
    input  logic           cfg_si,
    input  logic           cfg_shift,
    input  logic           cfg_update,
    output logic           cfg_so,
    output logic           tdi_encore,
    output logic           probe_valid
);

    localparam int SELW = clog2(NCH);
    localparam int CFGW = cfg_width(SELW);
    localparam int NPAD = 1 << SELW;

    typedef struct packed {
        mode_e            mode;
        logic [SELW-1:0]  sel;
    } cfg_t;

    logic            w_ten_s;
    logic [NCH-1:0]  w_i_s;
    logic [NCH-1:0]  r_i_s_d;
    logic [CFGW-1:0] r_sr;
    cfg_t            r_active;
    cfg_t            w_cfg_new;
    logic            r_hold;
    logic            r_sticky;
    logic            r_tdi;
    logic            r_valid;
    logic [NPAD-1:0] w_i_pad;
    logic [NPAD-1:0] w_id_pad;
    logic            w_shift;
    logic            w_update;
    logic            w_legal;
    logic            w_sel_bit;
    logic            w_sel_bit_d;
    logic            w_new_bit;
    logic            w_tdi_next;
    logic            w_valid_next;
    logic            w_unused_supply;

    dftprobe_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_ten (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (ten_encore),
        .o_q   (w_ten_s)
    );

    dftprobe_sync #(.W(NCH), .STAGES(SYNC_STAGES)) u_sync_i (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (i),
        .o_q   (w_i_s)
    );

    // Probe vectors padded to 2**SELW so an out-of-range select reads a 0.
    for (genvar gi = 0; gi < NPAD; gi++) begin : g_pad
        if (gi < NCH) begin : g_live
            assign w_i_pad[gi]  = w_i_s[gi];
            assign w_id_pad[gi] = r_i_s_d[gi];
        end else begin : g_fill
            assign w_i_pad[gi]  = 1'b0;
            assign w_id_pad[gi] = 1'b0;
        end
    end

    assign w_unused_supply = CELV ^ CELG ^ CELSUB;

    assign w_shift     = w_ten_s & cfg_shift;
    assign w_update    = w_ten_s & cfg_update & ~cfg_shift;
    assign w_cfg_new   = cfg_t'(r_sr);
    assign w_legal     = int'(r_active.sel) < NCH;
    assign w_sel_bit   = w_i_pad[r_active.sel];
    assign w_sel_bit_d = w_id_pad[r_active.sel];
    assign w_new_bit   = w_i_pad[w_cfg_new.sel];

    always_comb begin
        w_tdi_next   = 1'b0;
        w_valid_next = w_ten_s & (r_active.mode != MODE_OFF) & w_legal;
        if (w_ten_s && w_legal) begin
            case (r_active.mode)
                MODE_LIVE:   w_tdi_next = w_sel_bit;
                MODE_HOLD:   w_tdi_next = r_hold;
                MODE_STICKY: w_tdi_next = r_sticky;
                default:     w_tdi_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_s_d  <= '0;
            r_sr     <= '0;
            r_active <= '0;
            r_hold   <= 1'b0;
            r_sticky <= 1'b0;
            r_tdi    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_i_s_d <= w_i_s;
            r_tdi   <= w_tdi_next;
            r_valid <= w_valid_next;
            if (!w_ten_s) begin
                r_sr     <= '0;
                r_active <= '0;
                r_hold   <= 1'b0;
                r_sticky <= 1'b0;
            end else begin
                if (w_shift) begin
                    r_sr <= {r_sr[CFGW-2:0], cfg_si};
                end
                // An update clears sticky; only edges seen after it count.
                if (w_update) begin
                    r_active <= w_cfg_new;
                    r_hold   <= w_new_bit;
                    r_sticky <= 1'b0;
                end else if (r_active.mode == MODE_STICKY) begin
                    r_sticky <= r_sticky | (w_sel_bit & ~w_sel_bit_d);
                end
            end
        end
    end

    assign cfg_so      = r_sr[CFGW-1];
    assign tdi_encore  = r_tdi;
    assign probe_valid = r_valid;

endmodule

// File: tb/tb_dftprobe_chain.sv
// Directed bench for dftprobe_chain: an NCH=8 instance for the main modes and
// an NCH=6 instance sharing the config stream for illegal-select behaviour.
module tb_dftprobe_chain;

    localparam logic [1:0] M_OFF    = 2'b00;
    localparam logic [1:0] M_LIVE   = 2'b01;
    localparam logic [1:0] M_HOLD   = 2'b10;
    localparam logic [1:0] M_STICKY = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ten_encore;
    logic       cfg_si;
    logic       cfg_shift;
    logic       cfg_update;
    logic [7:0] i8;
    logic [5:0] i6;
    logic       so8, tdi8, val8;
    logic       so6, tdi6, val6;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dftprobe_chain #(.NCH(8), .SYNC_STAGES(2)) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .CELV        (1'b1),
        .CELG        (1'b0),
        .CELSUB      (1'b0),
        .ten_encore  (ten_encore),
        .i           (i8),
        .cfg_si      (cfg_si),
        .cfg_shift   (cfg_shift),
        .cfg_update  (cfg_update),
        .cfg_so      (so8),
        .tdi_encore  (tdi8),
        .probe_valid (val8)
    );

    dftprobe_chain #(.NCH(6), .SYNC_STAGES(2)) u_dut6 (
        .clk         (clk),
        .rst_n       (rst_n),
        .CELV        (1'b1),
        .CELG        (1'b0),
        .CELSUB      (1'b0),
        .ten_encore  (ten_encore),
        .i           (i6),
        .cfg_si      (cfg_si),
        .cfg_shift   (cfg_shift),
        .cfg_update  (cfg_update),
        .cfg_so      (so6),
        .tdi_encore  (tdi6),
        .probe_valid (val6)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %-16s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %-16s = %0h (t=%0t)", tag, got, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic shift_bit(input logic b, input logic upd);
        cfg_si     = b;
        cfg_shift  = 1'b1;
        cfg_update = upd;
        tick();
        cfg_shift  = 1'b0;
        cfg_update = 1'b0;
    endtask

    task automatic do_update();
        cfg_update = 1'b1;
        tick();
        cfg_update = 1'b0;
    endtask

    // Shifts {mode,sel} MSB first; with collide set the last shift also
    // raises cfg_update and no separate update follows.
    task automatic load_cfg(input logic [1:0] m, input logic [2:0] s, input logic collide);
        logic [4:0] w;
        w = {m, s};
        for (int b = 4; b >= 0; b--) shift_bit(w[b], collide && (b == 0));
        if (!collide) do_update();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic chain [15];
        logic [9:0] pat;

        rst_n = 1'b0; ten_encore = 1'b1; i8 = 8'hFF; i6 = 6'h3F;
        cfg_si = 1'b0; cfg_shift = 1'b0; cfg_update = 1'b0;

        // Reset holds everything low even with enable and probes high.
        ticks(3);
        check_vec("rst_tdi", tdi8, 1'b0);
        check_vec("rst_valid", val8, 1'b0);
        check_vec("rst_so", so8, 1'b0);
        rst_n = 1'b1;
        i8 = 8'h00;
        ticks(4);
        check_vec("pre_upd_tdi", tdi8, 1'b0);
        check_vec("pre_upd_valid", val8, 1'b0);
        check_vec("pre_upd_so", so8, 1'b0);

        // LIVE on channel 5: three-cycle pin-to-output latency.
        load_cfg(M_LIVE, 3'd5, 1'b0);
        tick();
        check_vec("live_valid", val8, 1'b1);
        check_vec("live_tdi0", tdi8, 1'b0);
        i8[5] = 1'b1;
        ticks(2);
        check_vec("live_lat2", tdi8, 1'b0);
        tick();
        check_vec("live_lat3", tdi8, 1'b1);
        i8[4] = 1'b1;
        ticks(4);
        check_vec("live_i4_hi", tdi8, 1'b1);
        i8[5] = 1'b0;
        ticks(3);
        check_vec("live_fall", tdi8, 1'b0);
        i8[4] = 1'b0;
        ticks(4);
        check_vec("live_i4_lo", tdi8, 1'b0);

        // HOLD on channel 2 captured high, then the pin drops.
        i8[2] = 1'b1;
        ticks(3);
        load_cfg(M_HOLD, 3'd2, 1'b0);
        i8[2] = 1'b0;
        tick();
        check_vec("hold_t1", tdi8, 1'b1);
        ticks(9);
        check_vec("hold_t10", tdi8, 1'b1);
        ticks(10);
        check_vec("hold_t20", tdi8, 1'b1);
        check_vec("hold_valid", val8, 1'b1);
        load_cfg(M_HOLD, 3'd2, 1'b0);
        tick();
        check_vec("hold_reload", tdi8, 1'b0);

        // STICKY on channel 7 with a one-cycle pulse.
        load_cfg(M_STICKY, 3'd7, 1'b0);
        tick();
        check_vec("sticky_idle", tdi8, 1'b0);
        i8[7] = 1'b1;
        tick();
        i8[7] = 1'b0;
        ticks(2);
        check_vec("sticky_p3", tdi8, 1'b0);
        tick();
        check_vec("sticky_p4", tdi8, 1'b1);
        ticks(10);
        check_vec("sticky_held", tdi8, 1'b1);
        load_cfg(M_STICKY, 3'd7, 1'b0);
        tick();
        check_vec("sticky_clear", tdi8, 1'b0);

        // Daisy chain: shift register starts as 11111 from the last load.
        pat = 10'b0110100011;
        for (int k = 0; k < 5; k++) chain[k] = 1'b1;
        for (int k = 0; k < 10; k++) chain[5 + k] = pat[9 - k];
        for (int k = 1; k <= 10; k++) begin
            shift_bit(chain[4 + k], 1'b0);
            check_vec($sformatf("chain_so%0d", k), so8, chain[k]);
        end

        // Shift/update collision: active LIVE sel1 must survive.
        load_cfg(M_LIVE, 3'd1, 1'b0);
        i8 = 8'hC0;
        ticks(3);
        check_vec("coll_before", tdi8, 1'b0);
        load_cfg(M_LIVE, 3'd6, 1'b1);
        tick();
        check_vec("coll_tdi", tdi8, 1'b0);
        check_vec("coll_so", so8, 1'b0);
        do_update();
        tick();
        check_vec("coll_upd_tdi", tdi8, 1'b1);
        i8[6] = 1'b0;
        ticks(3);
        check_vec("coll_sel6_lo", tdi8, 1'b0);
        i8[6] = 1'b1;
        ticks(3);
        check_vec("coll_sel6_hi", tdi8, 1'b1);

        // Test disable from LIVE.
        ten_encore = 1'b0;
        ticks(2);
        check_vec("dis_t2_tdi", tdi8, 1'b1);
        check_vec("dis_t2_valid", val8, 1'b1);
        tick();
        check_vec("dis_t3_tdi", tdi8, 1'b0);
        check_vec("dis_t3_valid", val8, 1'b0);
        for (int k = 0; k < 5; k++) shift_bit(1'b1, 1'b0);
        check_vec("dis_so", so8, 1'b0);
        ten_encore = 1'b1;
        ticks(3);
        check_vec("reen_valid", val8, 1'b0);
        check_vec("reen_tdi", tdi8, 1'b0);
        check_vec("reen_so", so8, 1'b0);

        // NCH=6 instance: legal select 5, then illegal select 7.
        load_cfg(M_LIVE, 3'd5, 1'b0);
        tick();
        check_vec("n6_sel5_valid", val6, 1'b1);
        check_vec("n6_sel5_tdi", tdi6, 1'b1);
        load_cfg(M_LIVE, 3'd7, 1'b0);
        tick();
        check_vec("n6_sel7_tdi", tdi6, 1'b0);
        check_vec("n6_sel7_valid", val6, 1'b0);
        check_vec("n8_sel7_valid", val8, 1'b1);

        // Reset in the middle of a shift discards the partial word.
        shift_bit(1'b1, 1'b0);
        shift_bit(1'b1, 1'b0);
        shift_bit(1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_vec("mid_rst_valid", val8, 1'b0);
        check_vec("mid_rst_tdi", tdi8, 1'b0);
        check_vec("mid_rst_so", so8, 1'b0);
        tick();
        rst_n = 1'b1;
        ticks(3);
        shift_bit(1'b1, 1'b0);
        shift_bit(1'b1, 1'b0);
        do_update();
        tick();
        check_vec("post_rst_valid", val8, 1'b0);
        check_vec("post_rst_so", so8, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dftprobe_chain.md
Name: dftprobe_chain

Overview:
- Parametrised multi-channel successor to the single-channel DFT TDI probe.
- Selects one of NCH internal probe inputs and drives it onto tdi_encore. Test enable is synchronised. Configuration is loaded serially, which gives chain-able probe blocks in the ATE service path.
- Adds three modes the single-channel probe lacks: live, hold and sticky-edge.
- Sits between the service/ATE controller and the encore TDI pad.

Parameters:
- NCH, 8: number of probe channels; 2..64.
- SYNC_STAGES, 2: synchroniser depth for ten_encore and i; 2..4.
- SELW, $clog2(NCH): derived; width of the channel select field. Not overridable.

Ports:
- clk  input  1  block clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- CELV  input  1  supply; pass-through only, no logic.
- CELG  input  1  ground; pass-through only, no logic.
- CELSUB  input  1  substrate; pass-through only, no logic.
- ten_encore  input  1  test enable; asynchronous to clk.
- i  input  NCH  probe inputs; asynchronous to clk.
- cfg_si  input  1  serial config data in.
- cfg_shift  input  1  shift config register one bit this cycle.
- cfg_update  input  1  transfer the shift register to the active config.
- cfg_so  output  1  serial config out, for daisy-chaining.
- tdi_encore  output  1  selected and processed probe value.
- probe_valid  output  1  high when the active config selects a legal channel with mode != OFF and test is enabled.

Behaviour:
- Clock and reset:
  - Single clock domain clk.
  - rst_n is asynchronous, active-low.
  - Reset state: all flops 0. So tdi_encore=0, probe_valid=0, cfg_so=0, shift reg=0, active cfg=0 (mode OFF, sel 0), sticky=0.
- Synchronisers:
  - ten_encore passes through SYNC_STAGES flops to give ten_s.
  - i[NCH-1:0] passes through SYNC_STAGES flops to give i_s.
- Config register:
  - CFGW = SELW+2, fields {mode[1:0], sel[SELW-1:0]}.
  - Shift, when ten_s & cfg_shift: sr <= {sr[CFGW-2:0], cfg_si}.
  - cfg_so = sr[CFGW-1], registered output of the shift register. Chain latency is CFGW cycles.
  - Update, when ten_s & cfg_update & !cfg_shift: active <= sr. Takes effect the next cycle.
  - cfg_shift and cfg_update asserted together: shift wins, update is dropped.
  - cfg_shift and cfg_update are ignored while ten_s=0.
- Modes (active.mode):
  - 00 OFF: tdi_encore=0.
  - 01 LIVE: tdi_encore <= i_s[sel] every cycle. Pin-to-output latency is SYNC_STAGES+1 cycles.
  - 10 HOLD: on the update cycle that enters HOLD, capture i_s[sel of the new config] into the hold flop. tdi_encore holds that value until the next update.
  - 11 STICKY: sticky <= sticky | (i_s[sel] & ~i_s_d[sel]), where i_s_d is i_s delayed one cycle. tdi_encore=sticky.
    - sticky clears on any update; the update cycle itself does not set sticky.
    - An edge that occurs on the cycle after an update is captured.
- Illegal select: sel >= NCH forces tdi_encore=0 and probe_valid=0. Applies only when NCH is not a power of 2.
- probe_valid: registered, ten_s & (mode != OFF) & (sel < NCH).
- Test disable: when ten_s falls, the next clock clears the active cfg, sr, hold and sticky. So tdi_encore=0 and probe_valid=0 one cycle after ten_s=0.
- Reset mid-shift: everything returns to reset values immediately. A partial shift is discarded.
- Supplies CELV, CELG and CELSUB are declared ports only, with no functional effect.

Decomposition:
- Package dftprobe_pkg holds:
  - mode constants MODE_OFF=2'b00, MODE_LIVE=2'b01, MODE_HOLD=2'b10, MODE_STICKY=2'b11;
  - cfg struct typedef, parametrised by SELW via function or localparam;
  - a clog2 helper.
- Sub-module dftprobe_sync holds the generic W-bit, SYNC_STAGES-deep synchroniser with async active-low reset. It is instantiated twice: W=1 for ten, W=NCH for i.

Test Plan:
- Reset and enable:
  - Stimulus: rst_n low while ten_encore=1 and i=all 1s.
  - Required: tdi_encore=0, probe_valid=0, cfg_so=0 throughout reset and until the first update.
- LIVE select and latency:
  - Stimulus: NCH=8. Shift in {01,3'd5}, LSB-last, in 5 cycles, then update. Toggle i[5].
  - Required: tdi_encore follows i[5] exactly 3 cycles later (SYNC_STAGES=2); probe_valid=1; i[4] toggles have no effect.
- HOLD:
  - Stimulus: load {10,3'd2} with i[2]=1 at update, then drive i[2]=0 for 20 cycles.
  - Required: tdi_encore stays 1.
  - Stimulus: reload with i[2]=0.
  - Required: tdi_encore=0.
- STICKY and daisy-chain:
  - Stimulus: load {11,3'd7}, single 1-cycle pulse on i[7].
  - Required: tdi_encore rises SYNC_STAGES+2 cycles after the pulse and stays 1; the next update clears it.
  - Stimulus: shift 10 more bits through.
  - Required: cfg_so reproduces cfg_si delayed 5 cycles.
- Shift/update collision:
  - Stimulus: cfg_shift=1 and cfg_update=1 in the same cycle.
  - Required: active cfg unchanged, shift register advanced.
- Test disable and illegal select:
  - Stimulus: deassert ten_encore in LIVE.
  - Required: tdi_encore=0 and probe_valid=0 within SYNC_STAGES+1 cycles; cfg_shift is then ignored.
  - Stimulus: NCH=6, load sel=7 with mode LIVE.
  - Required: tdi_encore=0, probe_valid=0.
